// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: controller for the panel shift register.
//
// Loads a byte from the switch panel into the top of the register, performs manual single
// shifts, and runs a timed automatic shift-out of all WIDTH bits at one shift every DIV
// cycles. Simultaneous panel commands are arbitrated abort > load > run > step.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   load_req   pulse: load load_data into shreg[WIDTH-1 -: 8] and hold
//   load_data  byte from the switches
//   step_req   pulse: one manual shift (IDLE only)
//   run_req    pulse: start automatic shift-out of WIDTH bits (IDLE only)
//   abort      pulse: stop and clear
//   serial_in  bit entering the MSB on every shift
//   shreg      register contents (LEDs)
//   ser_out    bit most recently shifted out of the LSB
//   hold       last loaded byte (hex display)
//   busy       high while running
//   done       one-cycle pulse after the last automatic shift
//   bit_cnt    shifts completed in the current run, saturates at WIDTH

module shift_seq_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_req,
    input  logic [7:0]                 load_data,
    input  logic                       step_req,
    input  logic                       run_req,
    input  logic                       abort,
    input  logic                       serial_in,
    output logic [WIDTH-1:0]           shreg,
    output logic                       ser_out,
    output logic [7:0]                 hold,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH):0]     bit_cnt
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    // Keep the divider at least one bit wide so DIV=1 still elaborates.
    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic              ser_out_q, ser_out_d;
    logic [7:0]        hold_q, hold_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DivW-1:0]   div_cnt_q, div_cnt_d;

    logic [WIDTH-1:0]  shreg_shifted;

    assign shreg_shifted = {serial_in, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        ser_out_d = ser_out_q;
        hold_d    = hold_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;

        unique case (state_q)
            StIdle: begin
                // Only the highest-priority request acts; the rest are dropped.
                if (abort) begin
                    shreg_d   = '0;
                    hold_d    = '0;
                    bit_cnt_d = '0;
                    ser_out_d = 1'b0;
                end else if (load_req) begin
                    shreg_d   = {load_data, {(WIDTH - 8){1'b0}}};
                    hold_d    = load_data;
                    bit_cnt_d = '0;
                end else if (run_req) begin
                    state_d   = StRun;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end else if (step_req) begin
                    shreg_d   = shreg_shifted;
                    ser_out_d = shreg_q[0];
                end
            end

            StRun: begin
                if (abort) begin
                    state_d   = StIdle;
                    shreg_d   = '0;
                    hold_d    = '0;
                    bit_cnt_d = '0;
                    ser_out_d = 1'b0;
                    div_cnt_d = '0;
                end else if (div_cnt_q == DivW'(DIV - 1)) begin
                    shreg_d   = shreg_shifted;
                    ser_out_d = shreg_q[0];
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = StDone;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            StDone: begin
                // Final contents and bit_cnt are kept unless aborted.
                state_d = StIdle;
                if (abort) begin
                    shreg_d   = '0;
                    hold_d    = '0;
                    bit_cnt_d = '0;
                    ser_out_d = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            ser_out_q <= 1'b0;
            hold_q    <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            ser_out_q <= ser_out_d;
            hold_q    <= hold_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign shreg   = shreg_q;
    assign ser_out = ser_out_q;
    assign hold    = hold_q;
    assign bit_cnt = bit_cnt_q;
    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl (WIDTH=16, DIV=4).

module tb_shift_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load_req;
    logic [7:0]  load_data;
    logic        step_req;
    logic        run_req;
    logic        abort;
    logic        serial_in;
    logic [15:0] shreg;
    logic        ser_out;
    logic [7:0]  hold;
    logic        busy;
    logic        done;
    logic [4:0]  bit_cnt;

    int n_checks = 0;
    int n_errors = 0;

    shift_seq_ctrl #(
        .WIDTH(16),
        .DIV  (4)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_req (load_req),
        .load_data(load_data),
        .step_req (step_req),
        .run_req  (run_req),
        .abort    (abort),
        .serial_in(serial_in),
        .shreg    (shreg),
        .ser_out  (ser_out),
        .hold     (hold),
        .busy     (busy),
        .done     (done),
        .bit_cnt  (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] data);
        load_req  = 1'b1;
        load_data = data;
        tick();
        load_req  = 1'b0;
    endtask

    task automatic do_run();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
    endtask

    task automatic wait_bit_cnt(input string tag, input logic [4:0] target);
        int n = 0;
        while (bit_cnt != target && n < 500) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(bit_cnt), 32'(target));
    endtask

    initial begin : main
        int          busy_cnt;
        int          done_cnt;
        int          first_shift;
        int          n;
        logic [4:0]  prev_cnt;
        logic [15:0] ser_seq;

        rst_n     = 1'b0;
        load_req  = 1'b0;
        load_data = 8'h00;
        step_req  = 1'b0;
        run_req   = 1'b0;
        abort     = 1'b0;
        serial_in = 1'b0;

        // Reset state
        #12;
        check_eq("rst_shreg", 32'(shreg), 32'h0);
        check_eq("rst_hold", 32'(hold), 32'h0);
        check_eq("rst_ser_out", 32'(ser_out), 32'h0);
        check_eq("rst_busy_done", {30'b0, busy, done}, 32'h0);
        check_eq("rst_bit_cnt", 32'(bit_cnt), 32'h0);
        #5 rst_n = 1'b1;
        tick();

        // Load 0xA5
        do_load(8'hA5);
        check_eq("load_shreg", 32'(shreg), 32'hA500);
        check_eq("load_hold", 32'(hold), 32'hA5);
        check_eq("load_busy", 32'(busy), 32'h0);

        // Manual steps
        serial_in = 1'b1;
        step_req  = 1'b1;
        tick();
        step_req  = 1'b0;
        check_eq("step1_shreg", 32'(shreg), 32'hD280);
        check_eq("step1_ser_out", 32'(ser_out), 32'h0);
        check_eq("step1_bit_cnt", 32'(bit_cnt), 32'h0);
        serial_in = 1'b0;
        step_req  = 1'b1;
        tick();
        step_req  = 1'b0;
        check_eq("step2_shreg", 32'(shreg), 32'h6940);
        check_eq("step2_ser_out", 32'(ser_out), 32'h0);

        // abort beats load in IDLE
        abort     = 1'b1;
        load_req  = 1'b1;
        load_data = 8'h77;
        tick();
        abort     = 1'b0;
        load_req  = 1'b0;
        check_eq("prio_abort_shreg", 32'(shreg), 32'h0);
        check_eq("prio_abort_hold", 32'(hold), 32'h0);

        // Full automatic run of 0xA500
        do_load(8'hA5);
        do_run();
        busy_cnt    = 0;
        done_cnt    = 0;
        first_shift = 0;
        prev_cnt    = 5'd0;
        ser_seq     = 16'h0;
        n           = 0;
        while (busy && n < 200) begin
            busy_cnt++;
            tick();
            n++;
            if (bit_cnt != prev_cnt) begin
                if (bit_cnt >= 5'd1 && bit_cnt <= 5'd16) ser_seq[bit_cnt - 5'd1] = ser_out;
                if (bit_cnt == 5'd1) first_shift = n;
                prev_cnt = bit_cnt;
            end
            if (done) done_cnt++;
        end
        check_eq("run_busy_cycles", 32'(busy_cnt), 32'd64);
        check_eq("run_first_shift", 32'(first_shift), 32'd4);
        check_eq("run_ser_seq", 32'(ser_seq), 32'hA500);
        check_eq("run_done_now", 32'(done), 32'h1);
        check_eq("run_end_shreg", 32'(shreg), 32'h0);
        check_eq("run_end_bit_cnt", 32'(bit_cnt), 32'd16);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check_eq("run_done_pulses", 32'(done_cnt), 32'd1);
        check_eq("run_bit_cnt_held", 32'(bit_cnt), 32'd16);
        check_eq("run_idle_busy", 32'(busy), 32'h0);

        // Abort after 5 shifts
        do_load(8'hA5);
        do_run();
        wait_bit_cnt("abort_wait5", 5'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'h0);
        check_eq("abort_shreg", 32'(shreg), 32'h0);
        check_eq("abort_hold", 32'(hold), 32'h0);
        check_eq("abort_bit_cnt", 32'(bit_cnt), 32'h0);
        check_eq("abort_ser_out", 32'(ser_out), 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (done || busy) done_cnt++;
            tick();
        end
        check_eq("abort_no_done", 32'(done_cnt), 32'h0);

        // Requests during RUN are ignored
        do_load(8'hA5);
        do_run();
        tick();
        tick();
        load_req  = 1'b1;
        load_data = 8'h3C;
        step_req  = 1'b1;
        tick();
        load_req  = 1'b0;
        step_req  = 1'b0;
        tick();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check_eq("ign_done_seen", 32'(done), 32'h1);
        check_eq("ign_hold", 32'(hold), 32'hA5);
        check_eq("ign_bit_cnt", 32'(bit_cnt), 32'd16);
        check_eq("ign_shreg", 32'(shreg), 32'h0);
        tick();

        // load beats run in IDLE
        load_req  = 1'b1;
        run_req   = 1'b1;
        load_data = 8'h3C;
        tick();
        load_req  = 1'b0;
        run_req   = 1'b0;
        check_eq("prio_load_hold", 32'(hold), 32'h3C);
        check_eq("prio_load_shreg", 32'(shreg), 32'h3C00);
        check_eq("prio_load_busy", 32'(busy), 32'h0);
        tick();
        check_eq("prio_load_busy2", 32'(busy), 32'h0);

        // Asynchronous reset mid-run
        do_load(8'hA5);
        do_run();
        wait_bit_cnt("rst_wait7", 5'd7);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_shreg", 32'(shreg), 32'h0);
        check_eq("arst_hold", 32'(hold), 32'h0);
        check_eq("arst_bit_cnt", 32'(bit_cnt), 32'h0);
        check_eq("arst_flags", {29'b0, busy, done, ser_out}, 32'h0);
        #13 rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        check_eq("arst_idle_no_done", 32'(done_cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
